// File: rtl/rom_burst_reader_if.sv
// Request and response channels of the burst ROM reader.
// The master issues bursts and consumes beats; the slave is the ROM.
interface rom_burst_reader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [LEN_WIDTH-1:0]  req_len;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  out_err;
    logic                  busy;

    modport master (
        output req_valid, req_addr, req_len, out_ready,
        input  req_ready, out_valid, out_data, out_last, out_err, busy
    );

    modport slave (
        input  req_valid, req_addr, req_len, out_ready,
        output req_ready, out_valid, out_data, out_last, out_err, busy
    );
endinterface

// File: rtl/rom_burst_reader.sv
// Constant-initialised ROM streamed out as wrapping bursts over valid/ready
// channels; a new burst can be accepted on the edge that retires the last beat.
module rom_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int INIT_COUNT = 20,
    parameter int LEN_WIDTH  = 4
) (
    input logic                clk,
    input logic                rst_n,
    rom_burst_reader_if.slave  bus
);
    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_nxt, addr_inc;
    logic [LEN_WIDTH-1:0]    remaining, rem_nxt;
    logic                    valid_q, valid_nxt;
    logic                    last_q, last_nxt;
    logic                    advance, ready, accept, in_range;

    // Full address space is populated so any addr_reg indexes legally;
    // words at or beyond DEPTH are zero and flagged by out_err instead.
    logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

    for (genvar i = 0; i < 2**ADDR_WIDTH; i++) begin : g_rom
        assign mem[i] = (i < DEPTH && i < INIT_COUNT) ? DATA_WIDTH'(i) : '0;
    end

    assign in_range = (32'(addr_reg) < DEPTH);
    assign addr_inc = (addr_reg == LAST_ADDR || addr_reg == '1) ? '0 : addr_reg + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_reg  <= '0;
            remaining <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr_reg  <= addr_nxt;
            remaining <= rem_nxt;
            valid_q   <= valid_nxt;
            last_q    <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_reg;
        rem_nxt   = remaining;
        valid_nxt = valid_q;
        last_nxt  = last_q;
        advance   = !valid_q || bus.out_ready;
        ready     = (state == IDLE) || (remaining == '0 && advance);
        accept    = bus.req_valid && ready;
        if (accept) begin
            // Takes priority over retiring the final beat: no bubble between bursts.
            state_nxt = BURST;
            addr_nxt  = bus.req_addr;
            rem_nxt   = bus.req_len;
            valid_nxt = 1'b1;
            last_nxt  = (bus.req_len == '0);
        end else if (state == BURST && advance) begin
            if (remaining != '0) begin
                addr_nxt = addr_inc;
                rem_nxt  = remaining - 1'b1;
                last_nxt = (remaining == LEN_WIDTH'(1));
            end else begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.out_valid = valid_q;
    assign bus.out_last  = last_q;
    assign bus.out_err   = !in_range;
    assign bus.out_data  = in_range ? mem[addr_reg] : '0;
    assign bus.busy      = (state == BURST);
endmodule

// File: tb/tb_rom_burst_reader.sv
// Drives two readers (DEPTH 256 and 200) with identical stimulus and checks
// every cycle against a queue-of-expected-beats model of the burst protocol.
module tb_rom_burst_reader;
    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       err;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [7:0] req_addr = '0;
    logic [3:0] req_len = '0;
    logic       out_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    bit acc;
    beat_t q0[$];
    beat_t q1[$];
    logic [7:0] seen[$];

    always #5 clk = ~clk;

    rom_burst_reader_if #(.ADDR_WIDTH(8), .LEN_WIDTH(4), .DATA_WIDTH(8)) ifa ();
    rom_burst_reader_if #(.ADDR_WIDTH(8), .LEN_WIDTH(4), .DATA_WIDTH(8)) ifb ();

    assign ifa.req_valid = req_valid;
    assign ifa.req_addr  = req_addr;
    assign ifa.req_len   = req_len;
    assign ifa.out_ready = out_ready;
    assign ifb.req_valid = req_valid;
    assign ifb.req_addr  = req_addr;
    assign ifb.req_len   = req_len;
    assign ifb.out_ready = out_ready;

    rom_burst_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(256), .INIT_COUNT(20), .LEN_WIDTH(4))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    rom_burst_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(200), .INIT_COUNT(20), .LEN_WIDTH(4))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expand a request into its beats using the address/contents rules directly.
    task automatic push_burst(input int d, input int a, input int l);
        int depth = (d == 0) ? 256 : 200;
        int ad = a;
        beat_t b;
        for (int i = 0; i <= l; i++) begin
            b.err  = (ad >= depth);
            b.data = (ad < depth && ad < 20) ? 8'(ad) : 8'h00;
            b.last = (i == l);
            if (d == 0) q0.push_back(b); else q1.push_back(b);
            ad = (ad == depth - 1 || ad == 255) ? 0 : ad + 1;
        end
    endtask

    // Called just after a negedge with inputs set; checks, updates model, moves to next negedge.
    task automatic step();
        logic exp_rdy;
        logic       o_rdy[2], o_vld[2], o_last[2], o_err[2], o_busy[2];
        logic [7:0] o_data[2];
        #1;
        exp_rdy = (q0.size() == 0) || (q0.size() == 1 && out_ready);
        o_rdy[0] = ifa.req_ready; o_vld[0] = ifa.out_valid; o_last[0] = ifa.out_last;
        o_err[0] = ifa.out_err;   o_busy[0] = ifa.busy;     o_data[0] = ifa.out_data;
        o_rdy[1] = ifb.req_ready; o_vld[1] = ifb.out_valid; o_last[1] = ifb.out_last;
        o_err[1] = ifb.out_err;   o_busy[1] = ifb.busy;     o_data[1] = ifb.out_data;
        for (int d = 0; d < 2; d++) begin
            beat_t e;
            int n;
            n = (d == 0) ? q0.size() : q1.size();
            chk($sformatf("d%0d_req_ready", d), o_rdy[d], exp_rdy);
            chk($sformatf("d%0d_out_valid", d), o_vld[d], n != 0);
            chk($sformatf("d%0d_busy", d), o_busy[d], n != 0);
            if (n != 0) begin
                e = (d == 0) ? q0[0] : q1[0];
                chk($sformatf("d%0d_data", d), o_data[d], e.data);
                chk($sformatf("d%0d_last", d), o_last[d], e.last);
                chk($sformatf("d%0d_err", d), o_err[d], e.err);
            end
        end
        acc = req_valid && exp_rdy;
        if (q0.size() != 0 && out_ready) begin
            seen.push_back(o_data[0]);
            q0.delete(0);
            q1.delete(0);
        end
        if (acc) begin
            push_burst(0, int'(req_addr), int'(req_len));
            push_burst(1, int'(req_addr), int'(req_len));
        end
        @(negedge clk);
    endtask

    task automatic send(input int a, input int l);
        bit done = 0;
        req_valid = 1'b1;
        req_addr  = 8'(a);
        req_len   = 4'(l);
        for (int i = 0; i < 64 && !done; i++) begin
            step();
            done = acc;
        end
        if (!done) chk("send_timeout", 0, 1);
        req_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Expected beats packed LSB-first: beat i is bytes[8*i +: 8].
    task automatic chk_seen(input string tag, input int n, input logic [63:0] bytes);
        chk({tag, "_count"}, seen.size(), n);
        for (int i = 0; i < n && i < seen.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), seen[i], bytes[8*i +: 8]);
        seen.delete();
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_req_ready", ifa.req_ready, 1);
        chk("rst_out_valid", ifa.out_valid, 0);
        chk("rst_out_last", ifa.out_last, 0);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_out_data", ifa.out_data, 0);
        chk("rst_out_err", ifb.out_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drain(2);

        seen.delete();
        send(5, 0);
        drain(3);
        chk_seen("single", 1, 64'h05);

        send(17, 4);
        drain(6);
        chk_seen("run17", 5, {8'h00, 8'h00, 8'h13, 8'h12, 8'h11});

        send(254, 3);
        drain(5);
        chk_seen("wrap254", 4, {8'h01, 8'h00, 8'h00, 8'h00});

        send(198, 2);
        drain(4);
        chk_seen("wrap198", 3, {8'h00, 8'h00, 8'h00});

        send(2, 3);
        step();
        out_ready = 1'b0;
        drain(3);
        out_ready = 1'b1;
        drain(4);
        chk_seen("bp", 4, {8'h05, 8'h04, 8'h03, 8'h02});

        send(0, 1);
        send(10, 1);
        drain(3);
        chk_seen("b2b", 4, {8'h0b, 8'h0a, 8'h01, 8'h00});

        send(210, 0);
        #1;
        chk("oor_err_b", ifb.out_err, 1);
        chk("oor_data_b", ifb.out_data, 0);
        chk("oor_err_a", ifa.out_err, 0);
        drain(2);
        seen.delete();

        send(3, 7);
        drain(2);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", ifa.out_valid, 0);
        chk("midrst_busy", ifa.busy, 0);
        chk("midrst_ready", ifa.req_ready, 1);
        chk("midrst_valid_b", ifb.out_valid, 0);
        q0.delete();
        q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drain(4);
        seen.delete();

        for (int i = 0; i < 400; i++) begin
            req_valid = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 3))
                0:       req_addr = 8'($urandom_range(250, 255));
                1:       req_addr = 8'($urandom_range(194, 205));
                2:       req_addr = 8'($urandom_range(0, 24));
                default: req_addr = 8'($urandom_range(0, 255));
            endcase
            req_len   = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        req_valid = 1'b0;
        out_ready = 1'b1;
        drain(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rom_burst_reader.md
# rom_burst_reader

Parametrised read-only memory with a request/response streaming front end. It replaces the fixed 256x8 single-port ROM, whose registered address drives an asynchronous array read. It accepts a start address and a burst length on a valid/ready request channel. It then streams consecutive words out on a valid/ready data channel, with address wrap-around, an out-of-range flag, backpressure and back-to-back bursts with no idle cycle between them.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 8, address width in bits
- DEPTH, 256, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH
- INIT_COUNT, 20, words 0..INIT_COUNT-1 hold their own index truncated to DATA_WIDTH; all other words hold 0
- LEN_WIDTH, 4, width of the burst-length field
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  burst request present
- req_ready  out  1  request accepted on a clk edge when req_valid && req_ready
- req_addr  in  ADDR_WIDTH  first word address
- req_len  in  LEN_WIDTH  beat count minus 1 (0 = single read)
- out_valid  out  1  out_data/out_last/out_err are valid
- out_ready  in  1  consumer takes the beat on a clk edge when out_valid && out_ready
- out_data  out  DATA_WIDTH  word read
- out_last  out  1  final beat of the burst
- out_err  out  1  beat address >= DEPTH; out_data is 0 for such a beat
- busy  out  1  a burst is in progress (state BURST)

## Operation
- Storage is a DEPTH-entry array initialised per INIT_COUNT. There is no write path.
- A registered address addr_reg drives the read: out_data = mem[addr_reg] when addr_reg < DEPTH, else 0. out_err = (addr_reg >= DEPTH).
- Registers: state (IDLE/BURST), addr_reg, remaining (LEN_WIDTH), out_valid, out_last.
- advance = !out_valid || out_ready.
- req_ready = (state==IDLE) || (state==BURST && remaining==0 && advance). It is combinational on out_ready.
- Accept (req_valid && req_ready):
  - addr_reg <= req_addr, remaining <= req_len
  - out_valid <= 1, out_last <= (req_len==0), state <= BURST
- BURST with advance and remaining > 0:
  - addr_reg <= next(addr_reg), remaining <= remaining-1, out_last <= (remaining==1)
- BURST with advance, remaining == 0 and no accept: out_valid <= 0, out_last <= 0, state <= IDLE.
- next(a): 0 if a == DEPTH-1 or a == 2**ADDR_WIDTH-1; otherwise a+1. An out-of-range start address counts up with out_err=1 until it wraps to 0.
- Stall: while out_valid && !out_ready, addr_reg, remaining, out_last and out_valid all hold. out_data is therefore stable.
- Accepting a request is the only way to leave IDLE. Requests are ignored while req_ready is 0.

## Timing
- Reset values: state IDLE, addr_reg 0, remaining 0, out_valid 0, out_last 0, busy 0. Consequently req_ready=1, out_data=mem[0], out_err=(DEPTH==0 ? n/a : 0).
- Latency: a request accepted on edge N presents its first beat from cycle N+1.
- Throughput: with out_ready held high, one beat per cycle. A burst of L+1 beats occupies cycles N+1..N+L+1.
- Back-to-back: a request accepted on the edge that consumes a last beat presents its first beat in the very next cycle, with no bubble.
- Reset asserted mid-burst: outputs return to their reset values immediately (asynchronously). The burst is discarded and nothing resumes after release.
- Simultaneous last-beat consume and new accept: the new burst wins, so out_valid stays 1.

## Test plan
- Defaults, reset, then req addr=5 len=0 -> one beat, out_data=0x05, out_last=1, out_err=0; then out_valid=0, req_ready=1.
- req addr=17 len=4, out_ready=1 -> beats 0x11,0x12,0x13,0x00,0x00 on 5 consecutive cycles; out_last only on the 5th.
- Wrap: req addr=254 len=3 -> data 0x00,0x00,0x00,0x01 (addresses 254,255,0,1). DEPTH=200 variant, addr=198 len=2 -> addresses 198,199,0.
- Backpressure: req addr=2 len=3 with out_ready low for 3 cycles at the 2nd beat -> 0x03 held steady, no beat lost or duplicated, sequence 0x02,0x03,0x04,0x05.
- Back-to-back: second req addr=10 len=1 held valid during the first burst (addr=0 len=1) -> stream 0x00,0x01,0x0a,0x0b with no gap in out_valid.
- DEPTH=200, req addr=210 len=0 -> out_data=0, out_err=1. Separately, rst_n pulsed low mid-burst -> out_valid=0 at once, req_ready=1 after release, no stale beats.
